// File: rtl/gp_noc_pkg.sv
// Shared sizing defaults for the NI, router and generic FIFOs of the NoC.
package gp_noc_pkg;
  localparam int GP_DATA_W = 64;
  localparam int GP_DEPTH  = 16;
  localparam int GP_PTR_W  = 4;
endpackage

// File: rtl/gp_fifo_if.sv
// Push/pop handshake and status bundle of gp_fifo; master = producer/consumer side.
interface gp_fifo_if
  import gp_noc_pkg::*;
#(
  parameter int DATA_WIDTH = GP_DATA_W,
  parameter int PTR_W      = GP_PTR_W
) ();
  logic                  write_en;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  error;
  logic                  full;
  logic                  empty;
  logic [PTR_W:0]        ocup;

  modport master (
    output write_en, read_en, data_in,
    input  data_out, error, full, empty, ocup
  );

  modport slave (
    input  write_en, read_en, data_in,
    output data_out, error, full, empty, ocup
  );
endinterface

// File: rtl/gp_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; only the pointers in gp_fifo define validity.
module gp_fifo_mem
  import gp_noc_pkg::*;
#(
  parameter int DATA_WIDTH = GP_DATA_W,
  parameter int DEPTH      = GP_DEPTH,
  parameter int PTR_W      = GP_PTR_W
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [PTR_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/gp_fifo.sv
// Circular-buffer FIFO with occupancy count, registered read data and a one-cycle error pulse.
// Reads have 1-cycle latency; overflowing writes and underflowing reads are dropped and flagged.
module gp_fifo
  import gp_noc_pkg::*;
#(
  parameter int DATA_WIDTH = GP_DATA_W,
  parameter int DEPTH      = GP_DEPTH,
  parameter int PTR_W      = GP_PTR_W
) (
  input  logic     clk,
  input  logic     reset,
  gp_fifo_if.slave bus
);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        ocup_q, ocup_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;

  assign full  = (ocup_q == CNT_FULL);
  assign empty = (ocup_q == '0);

  // A pop frees the head slot in the same edge, so a push into a full FIFO is legal alongside it.
  assign wr_acc = bus.write_en && (!full || bus.read_en);
  assign rd_acc = bus.read_en && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ocup_d     = ocup_q;
    data_out_d = data_out_q;
    error_d    = (bus.write_en && !wr_acc) || (bus.read_en && !rd_acc);

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = rd_data;
    end
    if (wr_acc && !rd_acc) begin
      ocup_d = ocup_q + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      ocup_d = ocup_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ocup_q     <= '0;
      data_out_q <= '0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ocup_q     <= ocup_d;
      data_out_q <= data_out_d;
      error_q    <= error_d;
    end
  end

  gp_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc && reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign bus.data_out = data_out_q;
  assign bus.error    = error_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.ocup     = ocup_q;
endmodule

// File: tb/tb_gp_fifo.sv
// Bench for gp_fifo: directed vector table, corner sequences and a randomized run against a queue model.
module tb_gp_fifo;
  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int PW    = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gp_fifo_if #(.DATA_WIDTH(DW), .PTR_W(PW)) bus ();

  gp_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_err  = 1'b0;

  typedef struct {
    bit            rst_n;
    bit            we;
    bit            re;
    logic [DW-1:0] din;
    int            exp_ocup;
    bit            exp_err;
    logic [DW-1:0] exp_dout;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive, advance the reference queue, compare all outputs against it.
  task automatic step(input bit rst_n, input bit we, input bit re, input logic [DW-1:0] din);
    bit can_rd, can_wr;
    reset        = rst_n;
    bus.write_en = we;
    bus.read_en  = re;
    bus.data_in  = din;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mq.delete();
      m_dout = '0;
      m_err  = 1'b0;
    end else begin
      can_rd = re && (mq.size() != 0);
      can_wr = we && (mq.size() < DEPTH || re);
      m_err  = (we && !can_wr) || (re && !can_rd);
      if (can_rd) m_dout = mq.pop_front();
      if (can_wr) mq.push_back(din);
    end
    chk("model_ocup",  DW'(bus.ocup),     DW'(mq.size()));
    chk("model_full",  DW'(bus.full),     DW'(mq.size() == DEPTH));
    chk("model_empty", DW'(bus.empty),    DW'(mq.size() == 0));
    chk("model_error", DW'(bus.error),    DW'(m_err));
    chk("model_dout",  bus.data_out,      m_dout);
  endtask

  initial begin
    reset        = 1'b0;
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    bus.data_in  = '0;

    // rst_n we re din                  ocup err dout
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 64'h5,                 0, 1'b0, 64'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 64'h0,                 0, 1'b0, 64'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 64'hA5A5A5A5A5A5A5A5,  1, 1'b0, 64'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 64'h0,                 1, 1'b0, 64'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 64'h0,                 1, 1'b0, 64'h0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 64'h35A5A5A5A5A5A5A5,  2, 1'b0, 64'h0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 64'h0,                 1, 1'b0, 64'hA5A5A5A5A5A5A5A5};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 64'h0,                 0, 1'b0, 64'h35A5A5A5A5A5A5A5};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 64'h0,                 0, 1'b1, 64'h35A5A5A5A5A5A5A5};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 64'h0,                 0, 1'b0, 64'h35A5A5A5A5A5A5A5};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 64'h77,                1, 1'b1, 64'h35A5A5A5A5A5A5A5};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 64'h0,                 0, 1'b0, 64'h77};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst_n, vecs[i].we, vecs[i].re, vecs[i].din);
      chk($sformatf("vec%0d_ocup", i), DW'(bus.ocup),  DW'(vecs[i].exp_ocup));
      chk($sformatf("vec%0d_err", i),  DW'(bus.error), DW'(vecs[i].exp_err));
      chk($sformatf("vec%0d_dout", i), bus.data_out,   vecs[i].exp_dout);
      if (vecs[i].exp_ocup == 0)
        chk($sformatf("vec%0d_empty", i), DW'(bus.empty), DW'(1));
    end

    // Fill to full, overflow with 99, then drain in order.
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, DW'(i));
    chk("fill_full", DW'(bus.full), DW'(1));
    chk("fill_ocup", DW'(bus.ocup), DW'(16));
    step(1'b1, 1'b1, 1'b0, DW'(99));
    chk("ovf_err",  DW'(bus.error), DW'(1));
    chk("ovf_ocup", DW'(bus.ocup),  DW'(16));
    step(1'b1, 1'b0, 1'b0, '0);
    chk("ovf_err_clear", DW'(bus.error), DW'(0));
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      chk($sformatf("drain%0d", i), bus.data_out, DW'(i));
    end
    chk("drain_empty", DW'(bus.empty), DW'(1));

    // Full with simultaneous push/pop: DEAD lands in the wrapped slot behind 15 older entries.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, DW'(100 + i));
    step(1'b1, 1'b1, 1'b1, 64'hDEAD);
    chk("rw_full_ocup", DW'(bus.ocup),  DW'(16));
    chk("rw_full_err",  DW'(bus.error), DW'(0));
    chk("rw_full_dout", bus.data_out,   DW'(100));
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      chk($sformatf("wrap%0d", i), bus.data_out, DW'(100 + i));
    end
    step(1'b1, 1'b0, 1'b1, '0);
    chk("wrap_dead", bus.data_out, 64'hDEAD);

    // Reset with five entries queued, then the first post-reset write.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, DW'(200 + i));
    step(1'b1, 1'b0, 1'b1, '0);
    chk("pre_rst_ocup", DW'(bus.ocup), DW'(5));
    step(1'b0, 1'b1, 1'b1, 64'h1234);
    chk("rst_ocup",  DW'(bus.ocup),  DW'(0));
    chk("rst_empty", DW'(bus.empty), DW'(1));
    chk("rst_dout",  bus.data_out,   DW'(0));
    step(1'b1, 1'b1, 1'b0, 64'h4321);
    chk("post_rst_ocup", DW'(bus.ocup), DW'(1));
    step(1'b1, 1'b0, 1'b1, '0);
    chk("post_rst_dout", bus.data_out, 64'h4321);

    // Randomized phases biased toward filling, draining, and balanced traffic.
    for (int c = 0; c < 3000; c++) begin
      int ph;
      bit we, re, rn;
      ph = (c / 200) % 3;
      we = (ph == 0) ? ($urandom_range(0, 9) < 8) : (ph == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 1) == 1);
      re = (ph == 0) ? ($urandom_range(0, 9) < 2) : (ph == 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 1) == 1);
      rn = ($urandom_range(0, 149) != 0);
      step(rn, we, re, {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
